// File: rtl/flt_pkg.sv
// Shared types, sizing helpers and reset-default coefficients for the folded FIR.
package flt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int NUM_TAPS_D  = 31;
  localparam int NUM_BANKS_D = 8;
  localparam int U           = (NUM_TAPS_D + 1) / 2;
  localparam int K_W         = clog2(U);
  localparam int BANK_W      = clog2(NUM_BANKS_D);

  // Centre tap just below unity, everything else zero: near pass-through.
  function automatic longint default_coef(input int idx, input int n_uniq, input int coef_w);
    return (idx == n_uniq - 1) ? ((longint'(1) << (coef_w - 1)) - 1) : longint'(0);
  endfunction

endpackage

// File: rtl/flt_coef_bank.sv
// NUM_BANKS x N_UNIQ coefficient register file, one write port, one combinational read port.
module flt_coef_bank
  import flt_pkg::*;
#(
  parameter int COEF_W    = 18,
  parameter int N_UNIQ    = 16,
  parameter int NUM_BANKS = 8,
  parameter int IDX_W     = 4,
  parameter int BNK_W     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [BNK_W-1:0]         wbank,
  input  logic [IDX_W-1:0]         waddr,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic [BNK_W-1:0]         rbank,
  input  logic [IDX_W-1:0]         ridx,
  output logic signed [COEF_W-1:0] rdata
);

  logic signed [COEF_W-1:0] mem [NUM_BANKS][N_UNIQ];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < N_UNIQ; i++)
          mem[b][i] <= COEF_W'(default_coef(i, N_UNIQ, COEF_W));
    end else if (we && (int'(wbank) < NUM_BANKS) && (int'(waddr) < N_UNIQ)) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if ((int'(rbank) < NUM_BANKS) && (int'(ridx) < N_UNIQ))
      rdata = mem[rbank][ridx];
  end

endmodule

// File: rtl/flt_fold_mac.sv
// Time-multiplexed symmetric FIR: one pre-adder and one multiplier, one unique tap per clock.
// state | meaning: IDLE = waiting for a sample, RUN = MAC over unique taps, OUT = y_valid cycle
module flt_fold_mac
  import flt_pkg::*;
#(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int NUM_TAPS  = NUM_TAPS_D,
  parameter int NUM_BANKS = NUM_BANKS_D,
  parameter int ACC_W     = 42,
  parameter int OUT_SHIFT = 17,
  localparam int N_UNIQ   = (NUM_TAPS + 1) / 2,
  localparam int IDX_W    = clog2(N_UNIQ),
  localparam int BNK_W    = clog2(NUM_BANKS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [BNK_W-1:0]         bank_sel,
  input  logic                     coef_we,
  input  logic [BNK_W-1:0]         coef_bank,
  input  logic [IDX_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_wr_err,
  output logic signed [DATA_W-1:0] y,
  output logic                     y_valid,
  output logic                     y_sat,
  output logic                     busy
);

  localparam int TAP_W  = clog2(NUM_TAPS);
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  state_t                   state;
  logic signed [DATA_W-1:0] dl [NUM_TAPS];
  logic [IDX_W-1:0]         k;
  logic [BNK_W-1:0]         act_bank;
  logic signed [ACC_W-1:0]  acc;

  logic signed [COEF_W-1:0] coef_rd;
  logic [TAP_W-1:0]         ka, kb;
  logic signed [DATA_W:0]   pre;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next, acc_sh;
  logic                     wr_block;

  assign busy     = (state != IDLE);
  assign x_ready  = (state == IDLE);
  assign wr_block = coef_we && busy && (coef_bank == act_bank);

  flt_coef_bank #(
    .COEF_W   (COEF_W),
    .N_UNIQ   (N_UNIQ),
    .NUM_BANKS(NUM_BANKS),
    .IDX_W    (IDX_W),
    .BNK_W    (BNK_W)
  ) u_coef (
    .clk  (clk),
    .reset(reset),
    .we   (coef_we && !wr_block),
    .wbank(coef_bank),
    .waddr(coef_addr),
    .wdata(coef_data),
    .rbank(act_bank),
    .ridx (k),
    .rdata(coef_rd)
  );

  // Fold: tap k pairs with its mirror; the centre tap stands alone.
  always_comb begin
    ka  = TAP_W'(k);
    kb  = TAP_W'(NUM_TAPS - 1) - ka;
    pre = '0;
    if (ka == TAP_W'(N_UNIQ - 1))
      pre = {dl[ka][DATA_W-1], dl[ka]};
    else
      pre = {dl[ka][DATA_W-1], dl[ka]} + {dl[kb][DATA_W-1], dl[kb]};
    prod     = PROD_W'(pre) * PROD_W'(coef_rd);
    acc_next = acc + ACC_W'(prod);
    acc_sh   = acc_next >>> OUT_SHIFT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      k           <= '0;
      act_bank    <= '0;
      acc         <= '0;
      y           <= '0;
      y_valid     <= 1'b0;
      y_sat       <= 1'b0;
      coef_wr_err <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) dl[i] <= '0;
    end else begin
      y_valid     <= 1'b0;
      coef_wr_err <= wr_block;
      case (state)
        IDLE: begin
          if (x_valid) begin
            for (int i = NUM_TAPS - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0]    <= x_in;
            act_bank <= bank_sel;
            acc      <= '0;
            k        <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (k == IDX_W'(N_UNIQ - 1)) begin
            if (acc_sh > Y_MAX) begin
              y     <= DATA_W'(Y_MAX);
              y_sat <= 1'b1;
            end else if (acc_sh < Y_MIN) begin
              y     <= DATA_W'(Y_MIN);
              y_sat <= 1'b1;
            end else begin
              y     <= DATA_W'(acc_sh);
              y_sat <= 1'b0;
            end
            y_valid <= 1'b1;
            state   <= OUT;
          end
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flt_fold_mac.sv
// Directed bench for flt_fold_mac: impulse, handshake, bank reload, saturation, write guard, reset abort.
module tb_flt_fold_mac;
  import flt_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic signed [17:0]       x_in = '0;
  logic                     x_valid = 1'b0;
  logic                     x_ready;
  logic [BANK_W-1:0]        bank_sel = '0;
  logic                     coef_we = 1'b0;
  logic [BANK_W-1:0]        coef_bank = '0;
  logic [K_W-1:0]           coef_addr = '0;
  logic signed [17:0]       coef_data = '0;
  logic                     coef_wr_err;
  logic signed [17:0]       y;
  logic                     y_valid;
  logic                     y_sat;
  logic                     busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flt_fold_mac dut (
    .clk        (clk),
    .reset      (reset),
    .x_in       (x_in),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .bank_sel   (bank_sel),
    .coef_we    (coef_we),
    .coef_bank  (coef_bank),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_wr_err(coef_wr_err),
    .y          (y),
    .y_valid    (y_valid),
    .y_sat      (y_sat),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    x_valid = 1'b0;
    coef_we = 1'b0;
    reset   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_coef(input int b, input int a, input int d);
    coef_we   = 1'b1;
    coef_bank = BANK_W'(b);
    coef_addr = K_W'(a);
    coef_data = 18'(d);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Entered and left on a falling edge; optional coefficient write in the first RUN cycle.
  task automatic run_sample(input int xv, input int bs, input bit do_wr, input int wb,
                            input int wa, input int wd, output logic signed [17:0] yo,
                            output logic so, output logic err1, output logic err2);
    int  n;
    bit  ok;
    x_in     = 18'(xv);
    bank_sel = BANK_W'(bs);
    x_valid  = 1'b1;
    n = 0;
    while (!x_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    err1 = 1'b0;
    err2 = 1'b0;
    if (do_wr) begin
      write_coef(wb, wa, wd);
      err1 = coef_wr_err;
      @(negedge clk);
      err2 = coef_wr_err;
    end
    ok = 1'b0;
    yo = 'x;
    so = 1'bx;
    if (y_valid) begin
      ok = 1'b1;
      yo = y;
      so = y_sat;
    end
    n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (y_valid) begin
        ok = 1'b1;
        yo = y;
        so = y_sat;
      end
    end
    chk("y_valid_seen", 64'(ok), 64'd1);
  endtask

  initial begin
    logic signed [17:0] yo;
    logic so, e1, e2;
    int xr_cnt, bz_cnt, yv_cnt, xr_first, xr_second, yv_first;

    // Reset state
    do_reset();
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_sat", y_sat, 0);
    chk("rst_wr_err", coef_wr_err, 0);
    chk("rst_x_ready", x_ready, 1);
    chk("rst_busy", busy, 0);

    // Impulse through the default bank
    for (int n = 1; n <= 31; n++) begin
      run_sample((n == 1) ? 1000 : 0, 0, 1'b0, 0, 0, 0, yo, so, e1, e2);
      chk($sformatf("imp_y%0d", n), yo, (n == 16) ? 999 : 0);
      if (n == 16) chk("imp_sat16", so, 0);
    end

    // Handshake timing with x_valid held high
    do_reset();
    x_in = '0; bank_sel = '0; x_valid = 1'b1;
    xr_cnt = 0; bz_cnt = 0; yv_cnt = 0;
    xr_first = -1; xr_second = -1; yv_first = -1;
    for (int c = 0; c < 36; c++) begin
      if (x_ready) begin
        xr_cnt++;
        if (xr_first < 0) xr_first = c;
        else if (xr_second < 0) xr_second = c;
      end
      if (busy) bz_cnt++;
      if (y_valid) begin
        yv_cnt++;
        if (yv_first < 0) yv_first = c;
      end
      @(negedge clk);
    end
    chk("hs_xready_cnt", xr_cnt, 2);
    chk("hs_busy_cnt", bz_cnt, 34);
    chk("hs_yvalid_cnt", yv_cnt, 2);
    chk("hs_period", xr_second - xr_first, 18);
    chk("hs_latency", yv_first - xr_first, 17);

    // Bank 1 reload: only the outer taps, at one half
    do_reset();
    write_coef(1, 15, 0);
    write_coef(1, 0, 65536);
    for (int n = 1; n <= 31; n++) begin
      run_sample((n == 1) ? 1000 : 0, 1, 1'b0, 0, 0, 0, yo, so, e1, e2);
      chk($sformatf("bank1_y%0d", n), yo, (n == 1 || n == 31) ? 500 : 0);
    end

    // Saturation, both rails
    do_reset();
    for (int a = 0; a < U; a++) write_coef(2, a, 131071);
    for (int n = 1; n <= 31; n++) begin
      run_sample(131071, 2, 1'b0, 0, 0, 0, yo, so, e1, e2);
      if (n == 31) begin
        chk("sat_pos_y", yo, 131071);
        chk("sat_pos_flag", so, 1);
      end
    end
    for (int n = 1; n <= 31; n++) begin
      run_sample(-131072, 2, 1'b0, 0, 0, 0, yo, so, e1, e2);
      if (n == 31) begin
        chk("sat_neg_y", yo, -131072);
        chk("sat_neg_flag", so, 1);
      end
    end

    // Write guard: active bank rejected, other bank accepted
    do_reset();
    run_sample(1000, 0, 1'b1, 0, 15, 0, yo, so, e1, e2);
    chk("wp_err_pulse", e1, 1);
    chk("wp_err_clear", e2, 0);
    run_sample(1000, 0, 1'b1, 3, 15, 0, yo, so, e1, e2);
    chk("wp_other_err", e1, 0);
    for (int n = 3; n <= 15; n++) run_sample(0, 0, 1'b0, 0, 0, 0, yo, so, e1, e2);
    run_sample(0, 0, 1'b0, 0, 0, 0, yo, so, e1, e2);
    chk("wp_bank0_y16", yo, 999);
    run_sample(0, 3, 1'b0, 0, 0, 0, yo, so, e1, e2);
    chk("wp_bank3_y17", yo, 0);

    // Reset in the middle of RUN
    do_reset();
    for (int n = 0; n < 3; n++) run_sample(5000, 0, 1'b0, 0, 0, 0, yo, so, e1, e2);
    x_in = 18'sd5000;
    x_valid = 1'b1;
    for (int n = 0; n < 40 && !x_ready; n++) @(negedge clk);
    @(posedge clk);
    repeat (8) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    reset = 1'b0;
    x_valid = 1'b0;
    #1;
    chk("mid_rst_yvalid", y_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    yv_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (y_valid) yv_cnt++;
    end
    chk("mid_no_yvalid", yv_cnt, 0);
    chk("mid_x_ready", x_ready, 1);
    for (int n = 1; n <= 31; n++) begin
      run_sample((n == 1) ? 1000 : 0, 0, 1'b0, 0, 0, 0, yo, so, e1, e2);
      chk($sformatf("mid_imp_y%0d", n), yo, (n == 16) ? 999 : 0);
    end

    x_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/flt_fold_mac.md
Name: flt_fold_mac

Overview:
- Parametrised, time-multiplexed successor to the team's fixed 31-tap symmetric FIR.
- Uses one pre-adder and one multiplier. It folds the symmetric impulse response and evaluates one unique tap per clock.
- Holds NUM_BANKS runtime-writable coefficient banks, selected per sample, in place of hard-wired switch tables.
- Sits between the sample source and the downstream decimator/DAC path, with a valid/ready input handshake and a valid-qualified output.

Parameters:
- DATA_W, 18, sample width of input and output (signed).
- COEF_W, 18, coefficient width (signed; 2^(COEF_W-1) represents 1.0 when OUT_SHIFT = COEF_W-1).
- NUM_TAPS, 31, filter length; must be odd. U = (NUM_TAPS+1)/2 unique coefficients.
- NUM_BANKS, 8, number of coefficient banks.
- ACC_W, 42, accumulator width; must be at least DATA_W+1+COEF_W+clog2(U).
- OUT_SHIFT, 17, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- x_in  in  DATA_W  input sample, signed
- x_valid  in  1  x_in valid
- x_ready  out  1  block can accept a sample
- bank_sel  in  clog2(NUM_BANKS)  bank to use for the next accepted sample
- coef_we  in  1  coefficient write strobe
- coef_bank  in  clog2(NUM_BANKS)  write bank
- coef_addr  in  clog2(U)  write index (U-1 = centre tap)
- coef_data  in  COEF_W  write value, signed
- coef_wr_err  out  1  one-cycle pulse: write rejected
- y  out  DATA_W  filtered sample, signed
- y_valid  out  1  one-cycle pulse: y updated
- y_sat  out  1  qualifies y_valid: this y was clamped
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, on reset=0):
  - state = IDLE; delay line x[0..NUM_TAPS-1] = 0; acc = 0; tap counter k = 0.
  - y = 0; y_valid = 0; y_sat = 0; coef_wr_err = 0.
  - Every bank is set to all zeros except coefficient U-1 = 2^(COEF_W-1)-1, so the default response is near-unity pass-through.
  - Reset mid-operation aborts the sample in flight; no y_valid is produced for it.
- FSM states are IDLE, RUN and OUT.
  - IDLE: x_ready = 1. On x_valid=1 at a clock edge:
    - shift the delay line (x[i] <= x[i-1], x[0] <= x_in);
    - latch bank_sel into act_bank;
    - clear acc and set k = 0;
    - go to RUN.
  - RUN: x_ready = 0. Each edge:
    - form pre = x[k] + x[NUM_TAPS-1-k] for k < U-1, or pre = x[U-1] for k = U-1; pre is DATA_W+1 bits with no pre-scaling;
    - prod = pre * coef[act_bank][k], full precision;
    - acc += sign-extended prod;
    - k++.
    - On the edge that processes k = U-1:
      - load y = sat(final_acc >>> OUT_SHIFT), clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
      - set y_sat accordingly;
      - go to OUT.
  - OUT: y_valid = 1 for exactly this one cycle; go to IDLE on the next edge. y holds its value until the next OUT.
- Timing:
  - Latency from the accept edge to the y_valid cycle is U edges (U = 16 at defaults).
  - Throughput is one sample per U+2 cycles.
  - The delay line shifts only on accept.
- bank_sel changes outside the accept edge are ignored.
- Coefficient writes:
  - A write lands on the edge where coef_we = 1.
  - It is rejected if busy = 1 and coef_bank == act_bank. In that case storage is unchanged and coef_wr_err pulses for one cycle.
  - Writes to other banks, or any write while IDLE, always land.
  - A write and an accept on the same edge to the bank being selected: the write lands, and the sample uses the new value.
- Rounding: the shift floors (arithmetic). There is no rounding.

Decomposition:
- Package flt_pkg holds:
  - FSM state encoding (IDLE, RUN, OUT);
  - a clog2 function;
  - localparams U, K_W, BANK_W;
  - default-coefficient function.
- Sub-module flt_coef_bank is the NUM_BANKS x U x COEF_W register file. It has an asynchronous reset to defaults, one write port and one combinational read port (bank, index).
- The FSM, delay line, pre-adder, MAC and saturation stay in flt_fold_mac.

Test Plan:
- Impulse path: after reset, bank 0, send x=1000 then zeros, with x_valid held at 1. Outputs 1-15 are 0, output 16 is y=999 with y_sat=0, and outputs 17-31 are 0.
- Handshake timing: x_valid held at 1. x_ready is high for 1 cycle in every 18, y_valid pulses 16 edges after each accept, and busy is high for 17 cycles per sample.
- Bank reload: while IDLE, write bank 1 addr 15 = 0 and addr 0 = 65536. With bank_sel=1, send an impulse of 1000. Only outputs 1 and 31 are 500; all others are 0.
- Saturation: write all 16 coefs of bank 2 = 131071 and feed 31 samples of 131071, giving y=131071 with y_sat=1. Repeat with -131072, giving y=-131072 with y_sat=1.
- Write protection: during RUN with act_bank=0, write bank 0 addr 15 = 0. coef_wr_err pulses once and the impulse still gives 999. The same write to bank 3 lands with no error.
- Reset mid-RUN: drop reset at k=7. y_valid stays 0, and x_ready=1 after release. The next impulse of 1000 reproduces the reset-default sequence, confirming the delay line was cleared.
